// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 8N1 UART receiver, 16x oversampled, majority vote of samples 7/8/9 per bit.
`timescale 1ns/1ps
module uart_rx_oversample #(
    parameter int CLKS_PER_TICK = 27,
    parameter int OVERSAMPLE    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_frame_err,
    output logic       rx_busy
);
    localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
    localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state;
    logic [1:0]    r_sync;
    logic          r_rx_prev;
    logic [TW-1:0] r_tick_cnt;
    logic [3:0]    r_samp_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shreg;
    logic [2:0]    r_votes;

    logic w_rx_s;
    logic w_fall;
    logic w_tick;
    logic w_vote;
    logic w_vote_stop;

    function automatic logic maj(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    assign w_rx_s      = r_sync[1];
    assign w_fall      = r_rx_prev & ~w_rx_s;
    assign w_tick      = r_tick_cnt == TICK_LAST;
    assign w_vote      = maj(r_votes);
    // The stop bit decides on the third sample's own tick, so that sample is taken live.
    assign w_vote_stop = maj({w_rx_s, r_votes[1:0]});
    assign rx_busy     = r_state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sync       <= 2'b11;
            r_rx_prev    <= 1'b1;
            r_tick_cnt   <= '0;
            r_samp_cnt   <= '0;
            r_bit_idx    <= '0;
            r_shreg      <= '0;
            r_votes      <= '0;
            rx_data      <= '0;
            rx_done      <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], rx};
            r_rx_prev    <= w_rx_s;
            rx_done      <= 1'b0;
            rx_frame_err <= 1'b0;
            if (r_state == IDLE) begin
                if (w_fall) begin
                    r_state    <= START;
                    r_tick_cnt <= '0;
                    r_samp_cnt <= '0;
                end
            end else begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
                if (w_tick) begin
                    r_samp_cnt <= r_samp_cnt + 4'd1;
                    if (r_samp_cnt == 4'd7) r_votes[0] <= w_rx_s;
                    if (r_samp_cnt == 4'd8) r_votes[1] <= w_rx_s;
                    if (r_samp_cnt == 4'd9) r_votes[2] <= w_rx_s;
                    case (r_state)
                        START: if (r_samp_cnt == SAMP_LAST) begin
                            r_state   <= w_vote ? IDLE : DATA;
                            r_bit_idx <= '0;
                        end
                        DATA: if (r_samp_cnt == SAMP_LAST) begin
                            r_shreg   <= {w_vote, r_shreg[7:1]};
                            r_state   <= (r_bit_idx == 3'd7) ? STOP : DATA;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                        STOP: if (r_samp_cnt == 4'd9) begin
                            r_state      <= IDLE;
                            rx_done      <= w_vote_stop;
                            rx_frame_err <= ~w_vote_stop;
                            if (w_vote_stop) rx_data <= r_shreg;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: scoreboard bench; expected frames are queued as they are sent.
`timescale 1ns/1ps
module tb_uart_rx_oversample;
    localparam int CPT = 4;
    localparam int BIT = 16 * CPT;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_frame_err;
    logic       rx_busy;

    exp_t       sb_q[$];
    logic [7:0] last_good = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    int         done_cyc = 0;

    uart_rx_oversample #(.CLKS_PER_TICK(CPT)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rx_frame_err(rx_frame_err),
        .rx_busy     (rx_busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (rx_done || rx_frame_err)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, rx_done, rx_frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                done_cyc = cyc;
                chk("pulse_kind", {30'd0, rx_done, rx_frame_err}, e.err ? 32'd1 : 32'd2);
                chk("pulse_data", {24'd0, rx_data}, {24'd0, e.data});
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic stop, input int per, input logic push);
        if (push) begin
            sb_q.push_back('{err: ~stop, data: stop ? b : last_good});
            if (stop) last_good = b;
        end
        rx = 1'b0;
        fall_cyc = cyc;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (per) @(negedge clk);
        end
        rx = stop;
        repeat (per) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (rx_busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {31'd0, rx_busy}, 32'd0);
        repeat (BIT) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data", {24'd0, rx_data}, 32'h00);
        chk("rst_done", {31'd0, rx_done}, 32'd0);
        chk("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
        chk("rst_busy", {31'd0, rx_busy}, 32'd0);
        repeat (BIT) @(negedge clk);

        send(8'hC3, 1'b1, BIT, 1'b1);
        wait_idle();
        chk("c3_latency", done_cyc - fall_cyc, 2 + (9 * 16 + 10) * CPT + 1);
        chk("c3_data", {24'd0, rx_data}, 32'hC3);

        send(8'hAA, 1'b1, BIT, 1'b1);
        send(8'h55, 1'b1, BIT, 1'b1);
        wait_idle();
        chk("b2b_data", {24'd0, rx_data}, 32'h55);

        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
        wait_idle();
        chk("glitch_data", {24'd0, rx_data}, 32'h55);

        send(8'h3C, 1'b0, BIT, 1'b1);
        rx = 1'b0;
        repeat (2000) @(negedge clk);
        chk("break_busy", {31'd0, rx_busy}, 32'd0);
        chk("ferr_data", {24'd0, rx_data}, 32'h55);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);

        fork
            send(8'hF0, 1'b1, BIT, 1'b0);
            begin
                repeat (5 * BIT + 20) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                last_good = 8'h00;
                chk("mid_rst_data", {24'd0, rx_data}, 32'h00);
                chk("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
                chk("mid_rst_done", {31'd0, rx_done}, 32'd0);
            end
        join
        wait_idle();
        send(8'h81, 1'b1, BIT, 1'b1);
        wait_idle();
        chk("post_rst_data", {24'd0, rx_data}, 32'h81);

        send(8'h5A, 1'b1, BIT - 2, 1'b1);
        wait_idle();
        chk("fast_data", {24'd0, rx_data}, 32'h5A);
        send(8'h00, 1'b1, BIT, 1'b1);
        wait_idle();
        send(8'h5A, 1'b1, BIT + 2, 1'b1);
        wait_idle();
        chk("slow_data", {24'd0, rx_data}, 32'h5A);

        chk("sb_pending", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
